// File: rtl/axis_image_dma_scheduler.sv
// Issues one DMA read command per image iteration on stream 1 (and stream 2 for maxpool layers),
// advancing addresses once the tlast of every active stream has been observed.
module axis_image_dma_scheduler #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BTT_WIDTH  = 23,
    parameter int unsigned BITS_ITER  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_base_1,
    input  logic [ADDR_WIDTH-1:0] cfg_base_2,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [BTT_WIDTH-1:0]  cfg_btt,
    input  logic [BITS_ITER-1:0]  cfg_iterations_1,
    input  logic                  cfg_is_max,
    output logic                  cmd_1_valid,
    input  logic                  cmd_1_ready,
    output logic [ADDR_WIDTH-1:0] cmd_1_addr,
    output logic [BTT_WIDTH-1:0]  cmd_1_btt,
    output logic                  cmd_2_valid,
    input  logic                  cmd_2_ready,
    output logic [ADDR_WIDTH-1:0] cmd_2_addr,
    output logic [BTT_WIDTH-1:0]  cmd_2_btt,
    input  logic                  mon_1_tvalid,
    input  logic                  mon_1_tready,
    input  logic                  mon_1_tlast,
    input  logic                  mon_2_tvalid,
    input  logic                  mon_2_tready,
    input  logic                  mon_2_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [BITS_ITER-1:0]  iter
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   stride;
    logic [BITS_ITER-1:0]    iterations_1;
    logic                    is_max;
    logic                    issued_1, issued_2;
    logic                    last_1, last_2;

    logic hs_1, hs_2, tl_1, tl_2, seen_1, seen_2, issue_complete, iter_complete;

    // Handshake and completion decode; stream-2 tlast only counts for maxpool layers
    assign hs_1           = cmd_1_valid && cmd_1_ready;
    assign hs_2           = cmd_2_valid && cmd_2_ready;
    assign tl_1           = mon_1_tvalid && mon_1_tready && mon_1_tlast;
    assign tl_2           = mon_2_tvalid && mon_2_tready && mon_2_tlast && is_max;
    assign seen_1         = last_1 || tl_1;
    assign seen_2         = last_2 || tl_2;
    assign issue_complete = (issued_1 || hs_1) && (issued_2 || hs_2 || !is_max);
    assign iter_complete  = seen_1 && (seen_2 || !is_max);

    assign cfg_ready = (state == IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            stride       <= '0;
            iterations_1 <= '0;
            is_max       <= 1'b0;
            issued_1     <= 1'b0;
            issued_2     <= 1'b0;
            last_1       <= 1'b0;
            last_2       <= 1'b0;
            cmd_1_valid  <= 1'b0;
            cmd_2_valid  <= 1'b0;
            cmd_1_addr   <= '0;
            cmd_2_addr   <= '0;
            cmd_1_btt    <= '0;
            cmd_2_btt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            iter         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        stride       <= cfg_stride;
                        iterations_1 <= cfg_iterations_1;
                        is_max       <= cfg_is_max;
                        cmd_1_addr   <= cfg_base_1;
                        cmd_2_addr   <= cfg_base_2;
                        cmd_1_btt    <= cfg_btt;
                        cmd_2_btt    <= cfg_btt;
                        iter         <= '0;
                        issued_1     <= 1'b0;
                        issued_2     <= 1'b0;
                        last_1       <= 1'b0;
                        last_2       <= 1'b0;
                        cmd_1_valid  <= 1'b1;
                        cmd_2_valid  <= cfg_is_max;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs_1) begin
                        issued_1    <= 1'b1;
                        cmd_1_valid <= 1'b0;
                    end
                    if (hs_2) begin
                        issued_2    <= 1'b1;
                        cmd_2_valid <= 1'b0;
                    end
                    last_1 <= seen_1;
                    last_2 <= seen_2;
                    if (issue_complete) state <= WAIT;
                end
                WAIT: begin
                    if (iter_complete) begin
                        issued_1 <= 1'b0;
                        issued_2 <= 1'b0;
                        last_1   <= 1'b0;
                        last_2   <= 1'b0;
                        if (iter == iterations_1) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            iter        <= iter + BITS_ITER'(1);
                            cmd_1_addr  <= cmd_1_addr + stride;
                            cmd_2_addr  <= cmd_2_addr + stride;
                            cmd_1_valid <= 1'b1;
                            cmd_2_valid <= is_max;
                            state       <= ISSUE;
                        end
                    end else begin
                        last_1 <= seen_1;
                        last_2 <= seen_2;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_image_dma_scheduler.sv
// Directed scenario bench for axis_image_dma_scheduler; each task drives one scenario and checks inline.
module tb_axis_image_dma_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_base_1 = '0, cfg_base_2 = '0, cfg_stride = '0;
    logic [22:0] cfg_btt = '0;
    logic [15:0] cfg_iterations_1 = '0;
    logic        cfg_is_max = 1'b0;
    logic        cmd_1_valid, cmd_2_valid;
    logic        cmd_1_ready = 1'b0, cmd_2_ready = 1'b0;
    logic [31:0] cmd_1_addr, cmd_2_addr;
    logic [22:0] cmd_1_btt, cmd_2_btt;
    logic        mon_1_tvalid = 1'b0, mon_1_tready = 1'b0, mon_1_tlast = 1'b0;
    logic        mon_2_tvalid = 1'b0, mon_2_tready = 1'b0, mon_2_tlast = 1'b0;
    logic        busy, done;
    logic [15:0] iter;

    int errors = 0;
    int checks = 0;
    int hs1_cnt = 0, hs2_cnt = 0, done_cnt = 0;

    axis_image_dma_scheduler #(.ADDR_WIDTH(32), .BTT_WIDTH(23), .BITS_ITER(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_base_1(cfg_base_1), .cfg_base_2(cfg_base_2), .cfg_stride(cfg_stride),
        .cfg_btt(cfg_btt), .cfg_iterations_1(cfg_iterations_1), .cfg_is_max(cfg_is_max),
        .cmd_1_valid(cmd_1_valid), .cmd_1_ready(cmd_1_ready), .cmd_1_addr(cmd_1_addr), .cmd_1_btt(cmd_1_btt),
        .cmd_2_valid(cmd_2_valid), .cmd_2_ready(cmd_2_ready), .cmd_2_addr(cmd_2_addr), .cmd_2_btt(cmd_2_btt),
        .mon_1_tvalid(mon_1_tvalid), .mon_1_tready(mon_1_tready), .mon_1_tlast(mon_1_tlast),
        .mon_2_tvalid(mon_2_tvalid), .mon_2_tready(mon_2_tready), .mon_2_tlast(mon_2_tlast),
        .busy(busy), .done(done), .iter(iter)
    );

    always #5 aclk = ~aclk;

    // Handshake and done-pulse counters
    always @(posedge aclk) begin
        if (cmd_1_valid && cmd_1_ready) hs1_cnt <= hs1_cnt + 1;
        if (cmd_2_valid && cmd_2_ready) hs2_cnt <= hs2_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cfg(input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] st,
                            input logic [22:0] btt, input logic [15:0] it, input logic mx);
        cfg_base_1 = b1; cfg_base_2 = b2; cfg_stride = st;
        cfg_btt = btt; cfg_iterations_1 = it; cfg_is_max = mx;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic set_mon1(input logic v);
        mon_1_tvalid = v; mon_1_tready = v; mon_1_tlast = v;
    endtask

    task automatic set_mon2(input logic v);
        mon_2_tvalid = v; mon_2_tready = v; mon_2_tlast = v;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({cmd_1_valid, cmd_2_valid, done} !== 3'b000) begin errors++; $display("FAIL reset_valids got=%b exp=000", {cmd_1_valid, cmd_2_valid, done}); end
        checks++; if (iter !== 16'd0) begin errors++; $display("FAIL reset_iter got=%0d exp=0", iter); end
        checks++; if ({cmd_1_addr, cmd_2_addr} !== 64'd0) begin errors++; $display("FAIL reset_addr got=%h/%h exp=0", cmd_1_addr, cmd_2_addr); end
        checks++; if ({cmd_1_btt, cmd_2_btt} !== 46'd0) begin errors++; $display("FAIL reset_btt got=%h/%h exp=0", cmd_1_btt, cmd_2_btt); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int h1 = hs1_cnt, h2 = hs2_cnt, d = done_cnt;
        send_cfg(32'h1000, 32'h0, 32'h0, 23'h200, 16'd0, 1'b0);
        checks++; if ({cmd_1_valid, cmd_2_valid} !== 2'b10) begin errors++; $display("FAIL single_valids got=%b exp=10", {cmd_1_valid, cmd_2_valid}); end
        checks++; if (cmd_1_addr !== 32'h1000 || cmd_1_btt !== 23'h200) begin errors++; $display("FAIL single_cmd got=%h/%h exp=1000/200", cmd_1_addr, cmd_1_btt); end
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL single_busy got=%b%b exp=10", busy, cfg_ready); end
        cmd_1_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0;
        checks++; if (cmd_1_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", cmd_1_valid); end
        set_mon1(1'b1);
        tick();
        set_mon1(1'b0);
        checks++; if (done !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL single_done got=%b%b exp=10", done, cfg_ready); end
        tick();
        checks++; if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b%b%b exp=010", done, cfg_ready, busy); end
        checks++; if (hs1_cnt - h1 !== 1 || hs2_cnt - h2 !== 0 || done_cnt - d !== 1) begin errors++; $display("FAIL single_counts got=%0d/%0d/%0d exp=1/0/1", hs1_cnt - h1, hs2_cnt - h2, done_cnt - d); end
    endtask

    task automatic test_multi();
        int d = done_cnt;
        send_cfg(32'h1000, 32'h8000, 32'h400, 23'h100, 16'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (iter !== 16'(i)) begin errors++; $display("FAIL multi_iter got=%0d exp=%0d", iter, i); end
            checks++; if (cmd_1_addr !== 32'h1000 + 32'h400 * 32'(i) || cmd_2_addr !== 32'h8000 + 32'h400 * 32'(i))
                begin errors++; $display("FAIL multi_addr it=%0d got=%h/%h exp=%h/%h", i, cmd_1_addr, cmd_2_addr, 32'h1000 + 32'h400 * 32'(i), 32'h8000 + 32'h400 * 32'(i)); end
            checks++; if ({cmd_1_valid, cmd_2_valid} !== 2'b11) begin errors++; $display("FAIL multi_valids it=%0d got=%b exp=11", i, {cmd_1_valid, cmd_2_valid}); end
            cmd_1_ready = 1'b1; cmd_2_ready = 1'b1;
            tick();
            cmd_1_ready = 1'b0; cmd_2_ready = 1'b0;
            set_mon2(1'b1);
            tick();
            set_mon2(1'b0);
            checks++; if ({cmd_1_valid, done} !== 2'b00) begin errors++; $display("FAIL multi_wait it=%0d got=%b exp=00", i, {cmd_1_valid, done}); end
            set_mon1(1'b1);
            tick();
            set_mon1(1'b0);
        end
        checks++; if (done !== 1'b1 || iter !== 16'd2) begin errors++; $display("FAIL multi_done got=%b/%0d exp=1/2", done, iter); end
        tick();
        checks++; if (done_cnt - d !== 1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL multi_one_done got=%0d/%b exp=1/1", done_cnt - d, cfg_ready); end
    endtask

    task automatic test_backpressure();
        int h1 = hs1_cnt;
        send_cfg(32'h2000, 32'h9000, 32'h100, 23'h40, 16'd1, 1'b1);
        cmd_1_ready = 1'b1; cmd_2_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if ({cmd_1_valid, cmd_2_valid} !== 2'b01 || cmd_2_addr !== 32'h9000 || cmd_2_btt !== 23'h40)
                begin errors++; $display("FAIL bp_hold cyc=%0d got=%b %h %h exp=01 9000 40", c, {cmd_1_valid, cmd_2_valid}, cmd_2_addr, cmd_2_btt); end
        end
        cmd_1_ready = 1'b0;
        checks++; if (hs1_cnt - h1 !== 1) begin errors++; $display("FAIL bp_one_beat got=%0d exp=1", hs1_cnt - h1); end
        cmd_2_ready = 1'b1;
        tick();
        cmd_2_ready = 1'b0;
        checks++; if (cmd_2_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", cmd_2_valid); end
        // Simultaneous tlasts advance exactly one iteration
        set_mon1(1'b1); set_mon2(1'b1);
        tick();
        set_mon1(1'b0); set_mon2(1'b0);
        checks++; if (iter !== 16'd1 || {cmd_1_valid, cmd_2_valid} !== 2'b11 || cmd_1_addr !== 32'h2100)
            begin errors++; $display("FAIL bp_simul got=%0d %b %h exp=1 11 2100", iter, {cmd_1_valid, cmd_2_valid}, cmd_1_addr); end
        cmd_1_ready = 1'b1; cmd_2_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0; cmd_2_ready = 1'b0;
        set_mon1(1'b1); set_mon2(1'b1);
        tick();
        set_mon1(1'b0); set_mon2(1'b0);
        checks++; if (done !== 1'b1 || iter !== 16'd1) begin errors++; $display("FAIL bp_done got=%b/%0d exp=1/1", done, iter); end
        tick();
    endtask

    task automatic test_ignore_stream2();
        send_cfg(32'h3000, 32'hA000, 32'h80, 23'h10, 16'd1, 1'b0);
        set_mon2(1'b1);
        checks++; if (cmd_2_valid !== 1'b0 || cmd_2_addr !== 32'hA000 || cmd_2_btt !== 23'h10)
            begin errors++; $display("FAIL ign_cmd2 got=%b %h %h exp=0 a000 10", cmd_2_valid, cmd_2_addr, cmd_2_btt); end
        cmd_1_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({cmd_1_valid, done} !== 2'b00 || iter !== 16'd0) begin errors++; $display("FAIL ign_wait cyc=%0d got=%b/%0d exp=00/0", c, {cmd_1_valid, done}, iter); end
        end
        set_mon1(1'b1);
        tick();
        set_mon1(1'b0);
        checks++; if (iter !== 16'd1 || cmd_1_valid !== 1'b1 || cmd_2_valid !== 1'b0 || cmd_1_addr !== 32'h3080 || cmd_2_addr !== 32'hA080)
            begin errors++; $display("FAIL ign_adv got=%0d %b%b %h %h exp=1 10 3080 a080", iter, cmd_1_valid, cmd_2_valid, cmd_1_addr, cmd_2_addr); end
        cmd_1_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0;
        set_mon1(1'b1);
        tick();
        set_mon1(1'b0);
        set_mon2(1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_wrap();
        send_cfg(32'hFFFF_FC00, 32'h0, 32'h400, 23'h20, 16'd1, 1'b0);
        cmd_1_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0;
        set_mon1(1'b1);
        tick();
        set_mon1(1'b0);
        checks++; if (cmd_1_addr !== 32'h0000_0000 || iter !== 16'd1 || cmd_1_valid !== 1'b1)
            begin errors++; $display("FAIL wrap_addr got=%h/%0d/%b exp=00000000/1/1", cmd_1_addr, iter, cmd_1_valid); end
        cmd_1_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0;
        set_mon1(1'b1);
        tick();
        set_mon1(1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        send_cfg(32'h4000, 32'hB000, 32'h200, 23'h80, 16'd3, 1'b1);
        cmd_1_ready = 1'b1; cmd_2_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0; cmd_2_ready = 1'b0;
        set_mon1(1'b1); set_mon2(1'b1);
        tick();
        set_mon1(1'b0); set_mon2(1'b0);
        cmd_1_ready = 1'b1; cmd_2_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0; cmd_2_ready = 1'b0;
        checks++; if (iter !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0d/%b exp=1/1", iter, busy); end
        aresetn = 1'b0;
        #2;
        checks++; if ({cmd_1_valid, cmd_2_valid, busy} !== 3'b000 || iter !== 16'd0 || cfg_ready !== 1'b1)
            begin errors++; $display("FAIL rmid_reset got=%b/%0d/%b exp=000/0/1", {cmd_1_valid, cmd_2_valid, busy}, iter, cfg_ready); end
        aresetn = 1'b1;
        tick();
        send_cfg(32'h5000, 32'hC000, 32'h10, 23'h8, 16'd0, 1'b1);
        checks++; if (cmd_1_addr !== 32'h5000 || cmd_2_addr !== 32'hC000 || {cmd_1_valid, cmd_2_valid} !== 2'b11)
            begin errors++; $display("FAIL rmid_restart got=%h/%h/%b exp=5000/c000/11", cmd_1_addr, cmd_2_addr, {cmd_1_valid, cmd_2_valid}); end
        cmd_1_ready = 1'b1; cmd_2_ready = 1'b1;
        tick();
        cmd_1_ready = 1'b0; cmd_2_ready = 1'b0;
        set_mon1(1'b1); set_mon2(1'b1);
        tick();
        set_mon1(1'b0); set_mon2(1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done got=%b exp=1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_ignore_stream2();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
